// File: rtl/enigma_return_path_if.sv
// Bus bundle for the Enigma return leg: upstream token port plus downstream result port.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds valid
// and its payload unchanged until that edge, and ready may depend combinationally on the
// downstream ready.
interface enigma_return_path_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_char;
  logic [14:0] in_pos;
  logic [14:0] in_ring;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_char;
  logic        out_err;

  modport slave (
    input  in_valid, in_char, in_pos, in_ring, out_ready,
    output in_ready, out_valid, out_char, out_err
  );

  modport master (
    output in_valid, in_char, in_pos, in_ring, out_ready,
    input  in_ready, out_valid, out_char, out_err
  );
endinterface

// File: rtl/enigma_return_path.sv
// Return (post-reflector) leg of the Enigma datapath: left, middle, then right rotor through the
// inverse wiring, one rotor per pipeline stage, each token carrying its own positions/rings.
module enigma_return_path #(
  parameter int ROTOR_L = 1,
  parameter int ROTOR_M = 2,
  parameter int ROTOR_R = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  enigma_return_path_if.slave  bus
);

  if (ROTOR_L < 1 || ROTOR_L > 3) begin : g_bad_rotor_l
    $error("ROTOR_L must be 1..3");
  end
  if (ROTOR_M < 1 || ROTOR_M > 3) begin : g_bad_rotor_m
    $error("ROTOR_M must be 1..3");
  end
  if (ROTOR_R < 1 || ROTOR_R > 3) begin : g_bad_rotor_r
    $error("ROTOR_R must be 1..3");
  end

  // Inverse wiring: index is the letter entering from the reflector side.
  localparam logic [4:0] INV_I [26] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
    5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
  };
  localparam logic [4:0] INV_II [26] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18
  };
  localparam logic [4:0] INV_III [26] = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
    5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12
  };

  function automatic logic [4:0] inv_wire(input int sel, input logic [5:0] idx);
    logic [4:0] w;
    w = 5'd0;
    if (idx < 6'd26) begin
      case (sel)
        1:       w = INV_I[idx[4:0]];
        2:       w = INV_II[idx[4:0]];
        default: w = INV_III[idx[4:0]];
      endcase
    end
    return w;
  endfunction

  // One rotor: shift by (pos-ring) into the wiring, look up, shift back; all mod 26.
  function automatic logic [4:0] rotor_pass(input int sel, input logic [4:0] c,
                                            input logic [4:0] pos, input logic [4:0] ring);
    logic [5:0] s, idx, w, o;
    if (pos >= ring) s = {1'b0, pos} - {1'b0, ring};
    else             s = {1'b0, pos} + 6'd26 - {1'b0, ring};
    idx = {1'b0, c} + s;
    if (idx >= 6'd26) idx = idx - 6'd26;
    w = {1'b0, inv_wire(sel, idx)};
    if (w >= s) o = w - s;
    else        o = w + 6'd26 - s;
    return o[4:0];
  endfunction

  function automatic logic field_bad(input logic [4:0] f);
    return f > 5'd25;
  endfunction

  logic       s1_valid, s2_valid, s3_valid;
  logic [4:0] s1_char, s2_char, s3_char;
  logic       s1_err, s2_err, s3_err;
  logic [9:0] s1_pos_mr, s1_ring_mr;
  logic [4:0] s2_pos_r, s2_ring_r;

  logic       s1_en, s2_en, s3_en;
  logic       in_err;
  logic [4:0] s1_char_d, s2_char_d, s3_char_d;

  // A stage may load when it is empty or its current token leaves this same cycle.
  assign s3_en = !s3_valid || bus.out_ready;
  assign s2_en = !s2_valid || s3_en;
  assign s1_en = !s1_valid || s2_en;

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s3_valid;
  assign bus.out_char  = s3_char;
  assign bus.out_err   = s3_err;

  always_comb begin
    in_err = field_bad(bus.in_char)
           || field_bad(bus.in_pos[14:10])  || field_bad(bus.in_pos[9:5])  || field_bad(bus.in_pos[4:0])
           || field_bad(bus.in_ring[14:10]) || field_bad(bus.in_ring[9:5]) || field_bad(bus.in_ring[4:0]);
    s1_char_d = in_err ? 5'd31
              : rotor_pass(ROTOR_L, bus.in_char, bus.in_pos[14:10], bus.in_ring[14:10]);
    s2_char_d = s1_err ? 5'd31
              : rotor_pass(ROTOR_M, s1_char, s1_pos_mr[9:5], s1_ring_mr[9:5]);
    s3_char_d = s2_err ? 5'd31
              : rotor_pass(ROTOR_R, s2_char, s2_pos_r, s2_ring_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_char    <= 5'd0;
      s1_err     <= 1'b0;
      s1_pos_mr  <= 10'd0;
      s1_ring_mr <= 10'd0;
      s2_valid   <= 1'b0;
      s2_char    <= 5'd0;
      s2_err     <= 1'b0;
      s2_pos_r   <= 5'd0;
      s2_ring_r  <= 5'd0;
      s3_valid   <= 1'b0;
      s3_char    <= 5'd0;
      s3_err     <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_char    <= s1_char_d;
          s1_err     <= in_err;
          s1_pos_mr  <= bus.in_pos[9:0];
          s1_ring_mr <= bus.in_ring[9:0];
        end
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_char   <= s2_char_d;
          s2_err    <= s1_err;
          s2_pos_r  <= s1_pos_mr[4:0];
          s2_ring_r <= s1_ring_mr[4:0];
        end
      end
      // Output register: holds char/err steady while downstream stalls.
      if (s3_en) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          s3_char <= s3_char_d;
          s3_err  <= s2_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_enigma_return_path.sv
// Randomised scoreboard bench for enigma_return_path against a letter-level Enigma model.
module tb_enigma_return_path;

  logic clk;
  logic rst;
  int   cyc = 0;

  enigma_return_path_if ifc();

  enigma_return_path dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [5:0] exp_q[$];
  int         acc_q[$];

  int   n_in = 0, n_out = 0;
  bit   lat_exact = 1'b1;
  bit   rand_ready = 1'b0;
  logic ready_level = 1'b1;
  bit   prev_stall = 1'b0;
  logic [4:0] prev_char;
  logic       prev_err;

  string inv_tab [3] = '{"UWYGADFPVZBECKMTHXSLRINQOJ",
                         "AJPCZWRLFBDKOTYUQGENHXMIVS",
                         "TAGBPCSDQEUFVNZHYIXJWLRKOM"};
  int rotor_sel [3] = '{1, 2, 3};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: letter arithmetic straight from the rotor rules, {err,char}.
  function automatic logic [5:0] model(input int c, input logic [14:0] p, input logic [14:0] r);
    int x, s, pk, rk;
    bit illegal;
    illegal = (c > 25);
    for (int k = 0; k < 3; k++) begin
      pk = int'((p >> (10 - 5*k)) & 15'h1f);
      rk = int'((r >> (10 - 5*k)) & 15'h1f);
      if (pk > 25 || rk > 25) illegal = 1'b1;
    end
    if (illegal) return {1'b1, 5'd31};
    x = c;
    for (int k = 0; k < 3; k++) begin
      pk = int'((p >> (10 - 5*k)) & 15'h1f);
      rk = int'((r >> (10 - 5*k)) & 15'h1f);
      s  = (pk - rk + 26) % 26;
      x  = int'(inv_tab[rotor_sel[k] - 1].getc((x + s) % 26)) - 65;
      x  = (x - s + 26) % 26;
    end
    return {1'b0, 5'(x)};
  endfunction

  task automatic send(input logic [4:0] c, input logic [14:0] p, input logic [14:0] r,
                      input logic [5:0] e);
    int tries;
    tries = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_char  = c;
    ifc.in_pos   = p;
    ifc.in_ring  = r;
    forever begin
      #3;
      if (ifc.in_ready) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        break;
      end
      tries++;
      if (tries > 500) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Downstream ready driver.
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rand_ready) ifc.out_ready = 1'($urandom_range(0, 1));
      else            ifc.out_ready = ready_level;
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    int occ;
    logic [5:0] e;
    int a;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        occ = n_in - n_out;
        chk("in_ready", int'(ifc.in_ready), int'(!(occ == 3 && !ifc.out_ready)));
        if (prev_stall) begin
          chk("hold_valid", int'(ifc.out_valid), 1);
          chk("hold_char", int'(ifc.out_char), int'(prev_char));
          chk("hold_err", int'(ifc.out_err), int'(prev_err));
        end
        if (ifc.out_valid && ifc.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(ifc.out_char), -1);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            chk("out_char", int'(ifc.out_char), int'(e[4:0]));
            chk("out_err", int'(ifc.out_err), int'(e[5]));
            if (lat_exact) chk("latency", cyc - a, 3);
            else           chk("latency_min", int'((cyc - a) >= 3), 1);
          end
          n_out++;
        end
        if (ifc.in_valid && ifc.in_ready) n_in++;
        prev_stall = ifc.out_valid && !ifc.out_ready;
        prev_char  = ifc.out_char;
        prev_err   = ifc.out_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  c;
    logic [14:0] p, r;
    rst          = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_char  = 5'd0;
    ifc.in_pos   = 15'd0;
    ifc.in_ring  = 15'd0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(ifc.out_valid), 0);
    chk("rst_out_char", int'(ifc.out_char), 0);
    chk("rst_out_err", int'(ifc.out_err), 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(ifc.in_ready), 1);

    // Known-answer tokens with exact 3-cycle latency.
    send(5'd0, 15'd0, 15'd0, {1'b0, 5'd3});
    idle();
    drain();
    send(5'd0, 15'd1, 15'd0, {1'b0, 5'd15});
    send(5'd0, 15'd1, 15'd1, {1'b0, 5'd3});
    send(5'd25, 15'd0, 15'd0, {1'b0, 5'd0});
    idle();
    drain();

    // Back-to-back sweep of every letter.
    for (int i = 0; i < 26; i++) send(5'(i), 15'd0, 15'd0, model(i, 15'd0, 15'd0));
    idle();
    drain();

    // Illegal codes flow through in order without disturbing neighbours.
    send(5'd30, 15'd0, 15'd0, {1'b1, 5'd31});
    send(5'd0, 15'd0, 15'd0, {1'b0, 5'd3});
    send(5'd4, {5'd26, 5'd0, 5'd0}, 15'd0, {1'b1, 5'd31});
    send(5'd5, 15'd0, {5'd0, 5'd0, 5'd31}, {1'b1, 5'd31});
    send(5'd0, 15'd0, 15'd0, {1'b0, 5'd3});
    idle();
    drain();

    // Random tokens under random downstream stalls.
    lat_exact  = 1'b0;
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      c = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      for (int k = 0; k < 3; k++) begin
        p[5*k +: 5] = ($urandom_range(0, 40) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
        r[5*k +: 5] = ($urandom_range(0, 40) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      end
      send(c, p, r, model(int'(c), p, r));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    rand_ready  = 1'b0;
    ready_level = 1'b1;
    drain();

    // Asynchronous reset with three tokens stuck in the pipe.
    ready_level = 1'b0;
    idle();
    send(5'd1, 15'd0, 15'd0, model(1, 15'd0, 15'd0));
    send(5'd2, 15'd0, 15'd0, model(2, 15'd0, 15'd0));
    send(5'd3, 15'd0, 15'd0, model(3, 15'd0, 15'd0));
    idle();
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(ifc.out_valid), 0);
    chk("async_rst_in_ready", int'(ifc.in_ready), 1);
    exp_q.delete();
    acc_q.delete();
    n_in       = 0;
    n_out      = 0;
    prev_stall = 1'b0;
    ready_level = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("no_stale", int'(ifc.out_valid), 0);
    end
    lat_exact = 1'b1;
    send(5'd0, 15'd0, 15'd0, {1'b0, 5'd3});
    idle();
    drain();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
